// File: rtl/inst_loader_pkg.sv
// Shared types and sizing helpers for the instruction-memory boot loader.
package inst_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } loader_state_e;

    localparam int LenBytes  = 4;
    localparam int WordBytes = 4;

    function automatic int max_words(input int mem_bytes);
        return mem_bytes / WordBytes;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs little-endian bytes into 32-bit words; word_valid_o pulses the cycle
// after the fourth byte of a word is taken.
module word_assembler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        valid_i,
    input  logic [7:0]  byte_i,
    output logic        last_lane_o,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  lane_q;
    logic [23:0] sh_q;
    logic [31:0] word_q;
    logic        word_valid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lane_q       <= 2'd0;
            sh_q         <= 24'd0;
            word_q       <= 32'd0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            if (clear_i) begin
                lane_q <= 2'd0;
            end else if (valid_i) begin
                // Newest byte enters at the top so lane 0 ends up in bits [7:0].
                sh_q   <= {byte_i, sh_q[23:8]};
                lane_q <= lane_q + 2'd1;
                if (lane_q == 2'd3) begin
                    word_q       <= {byte_i, sh_q};
                    word_valid_q <= 1'b1;
                end
            end
        end
    end

    assign last_lane_o  = (lane_q == 2'd3);
    assign word_o       = word_q;
    assign word_valid_o = word_valid_q;

endmodule

// File: rtl/inst_mem_loader.sv
// Boot loader: parses length/payload/checksum from a byte stream, writes words
// to instruction memory and releases the core only after a good checksum.
module inst_mem_loader
    import inst_loader_pkg::*;
#(
    parameter int MemoryBytesSize = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_byte,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_we,
    output logic [31:0] o_waddr,
    output logic [31:0] o_wdata,
    output logic        o_cpu_hold,
    output logic        o_done,
    output logic        o_error,
    output logic [2:0]  o_state
);

    localparam int MaxWords = max_words(MemoryBytesSize);
    localparam int IdxW     = $clog2(MaxWords) + 1;
    localparam int LenCntW  = $clog2(LenBytes);

    loader_state_e      state_q;
    logic [LenCntW-1:0] len_cnt_q;
    logic [31:0]        n_q;
    logic [IdxW-1:0]    word_idx_q;
    logic [7:0]         sum_q;
    logic [31:0]        waddr_q;
    logic               ready_q;
    logic               done_q;
    logic               error_q;
    logic               hold_q;

    logic        accept;
    logic [31:0] n_d;
    logic        asm_last;
    logic [31:0] asm_word;
    logic        asm_word_valid;

    assign accept = i_valid && ready_q;
    assign n_d    = {i_byte, n_q[31:8]};

    word_assembler u_asm (
        .clk_i        (i_clk),
        .rst_i        (i_rst),
        .clear_i      (state_q != ST_DATA),
        .valid_i      (accept && (state_q == ST_DATA)),
        .byte_i       (i_byte),
        .last_lane_o  (asm_last),
        .word_o       (asm_word),
        .word_valid_o (asm_word_valid)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_LEN;
            len_cnt_q  <= '0;
            n_q        <= 32'd0;
            word_idx_q <= '0;
            sum_q      <= 8'd0;
            waddr_q    <= 32'd0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            hold_q     <= 1'b1;
        end else begin
            case (state_q)
                ST_LEN: begin
                    if (accept) begin
                        n_q       <= n_d;
                        len_cnt_q <= len_cnt_q + LenCntW'(1);
                        if (len_cnt_q == LenCntW'(LenBytes - 1)) begin
                            // Full 32-bit compare so a large upper byte cannot alias a small length.
                            if (n_d > 32'(MaxWords)) begin
                                state_q <= ST_ERR;
                                ready_q <= 1'b0;
                                error_q <= 1'b1;
                            end else if (n_d == 32'd0) begin
                                state_q <= ST_CSUM;
                            end else begin
                                state_q <= ST_DATA;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        sum_q <= sum_q + i_byte;
                        if (asm_last) begin
                            waddr_q    <= 32'(word_idx_q) << 2;
                            word_idx_q <= word_idx_q + IdxW'(1);
                            if (32'(word_idx_q) == n_q - 32'd1) begin
                                state_q <= ST_CSUM;
                            end
                        end
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        if (i_byte == sum_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                        end else begin
                            state_q <= ST_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_ready    = ready_q;
    assign o_we       = asm_word_valid;
    assign o_waddr    = waddr_q;
    assign o_wdata    = asm_word;
    assign o_cpu_hold = hold_q;
    assign o_done     = done_q;
    assign o_error    = error_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomised bench for inst_mem_loader: a stream-level reference model feeds
// an expected-write queue that a free-running monitor drains.
module tb_inst_mem_loader;

    localparam int MEM  = 256;
    localparam int MAXW = MEM / 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i_byte;
    logic        i_valid;
    logic        o_ready;
    logic        o_we;
    logic [31:0] o_waddr;
    logic [31:0] o_wdata;
    logic        o_cpu_hold;
    logic        o_done;
    logic        o_error;
    logic [2:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [95:0] exp_q[$];
    logic [7:0]  stream[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    inst_mem_loader #(.MemoryBytesSize(MEM)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_byte     (i_byte),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_we       (o_we),
        .o_waddr    (o_waddr),
        .o_wdata    (o_wdata),
        .o_cpu_hold (o_cpu_hold),
        .o_done     (o_done),
        .o_error    (o_error),
        .o_state    (dbg_state)
    );

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("done_error_exclusive", 64'(o_done & o_error), 64'd0);
            if (o_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=%0h data=%0h required=no write", o_waddr, o_wdata);
                end else begin
                    logic [95:0] e;
                    e = exp_q.pop_front();
                    check_eq("wr_cycle", 64'(cyc), 64'(e[95:64]));
                    check_eq("wr_addr", 64'(o_waddr), 64'(e[63:32]));
                    check_eq("wr_data", 64'(o_wdata), 64'(e[31:0]));
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ready"}, 64'(o_ready), 64'd1);
        check_eq({tag, "_we"}, 64'(o_we), 64'd0);
        check_eq({tag, "_waddr"}, 64'(o_waddr), 64'd0);
        check_eq({tag, "_wdata"}, 64'(o_wdata), 64'd0);
        check_eq({tag, "_hold"}, 64'(o_cpu_hold), 64'd1);
        check_eq({tag, "_done"}, 64'(o_done), 64'd0);
        check_eq({tag, "_error"}, 64'(o_error), 64'd0);
        check_eq({tag, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        i_valid = 1'b0;
        #1;
        check_reset_vals("rst");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model + driver. stop_after>=0 truncates the stream and skips end checks.
    task automatic run_stream(input int max_gap, input int stop_after);
        logic [31:0] nw;
        logic [7:0]  sum;
        int          n;
        int          n_acc;
        bit          exp_done;
        int          gap;
        nw = {stream[3], stream[2], stream[1], stream[0]};
        if (nw > 32'(MAXW)) begin
            n        = 0;
            n_acc    = 4;
            exp_done = 1'b0;
        end else begin
            n   = int'(nw);
            sum = 8'd0;
            for (int k = 0; k < 4 * n; k++) sum = sum + stream[4 + k];
            n_acc    = 5 + 4 * n;
            exp_done = (stream[4 + 4 * n] == sum);
        end
        if (stop_after >= 0) n_acc = stop_after;
        for (int i = 0; i < n_acc; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin
                @(negedge clk);
                i_valid = 1'b0;
            end
            @(negedge clk);
            i_valid = 1'b1;
            i_byte  = stream[i];
            check_eq("ready_in_stream", 64'(o_ready), 64'd1);
            if (i >= 4 && i < 4 + 4 * n && ((i - 4) % 4) == 3)
                exp_q.push_back({32'(cyc + 1), 32'(i - 7),
                                 stream[i], stream[i - 1], stream[i - 2], stream[i - 3]});
        end
        @(negedge clk);
        i_valid = 1'b0;
        if (stop_after < 0) begin
            check_eq("done", 64'(o_done), 64'(exp_done));
            check_eq("error", 64'(o_error), 64'(!exp_done));
            check_eq("cpu_hold", 64'(o_cpu_hold), 64'(!exp_done));
            check_eq("ready_end", 64'(o_ready), 64'd0);
            @(negedge clk);
            check_eq("pending_writes", 64'(exp_q.size()), 64'd0);
            repeat (3) begin
                @(negedge clk);
                i_valid = 1'b1;
                i_byte  = 8'($urandom);
                check_eq("ready_after_end", 64'(o_ready), 64'd0);
            end
            @(negedge clk);
            i_valid = 1'b0;
            check_eq("done_sticky", 64'(o_done), 64'(exp_done));
            check_eq("error_sticky", 64'(o_error), 64'(!exp_done));
        end
    endtask

    task automatic build_random(input int n, input bit good);
        logic [7:0] s;
        logic [7:0] b;
        stream.delete();
        stream.push_back(8'(n));
        stream.push_back(8'(n >> 8));
        stream.push_back(8'd0);
        stream.push_back(8'd0);
        s = 8'd0;
        for (int k = 0; k < 4 * n; k++) begin
            b = 8'($urandom);
            s = s + b;
            stream.push_back(b);
        end
        stream.push_back(good ? s : s + 8'($urandom_range(255, 1)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        i_valid = 1'b0;
        i_byte  = 8'd0;
        do_reset();

        stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00, 8'hBB};
        run_stream(0, -1);
        do_reset();

        stream[12] = 8'hBC;
        run_stream(0, -1);
        do_reset();

        stream = '{8'h41, 8'h00, 8'h00, 8'h00};
        run_stream(0, -1);
        do_reset();

        stream = '{8'h01, 8'h00, 8'h01, 8'h00};
        run_stream(0, -1);
        do_reset();

        stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_stream(0, -1);
        do_reset();

        stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        run_stream(0, -1);
        do_reset();

        stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00, 8'hBB};
        run_stream(5, -1);
        do_reset();

        for (int t = 0; t < 6; t++) begin
            build_random(int'($urandom_range(8, 1)), 1'($urandom_range(1, 0)));
            run_stream(3, -1);
            do_reset();
        end

        build_random(MAXW, 1'b1);
        run_stream(0, -1);
        do_reset();

        // Reset after 6 payload bytes: word 0 is written, the partial word 1 must vanish.
        stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00, 8'hBB};
        run_stream(0, 10);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        check_eq("mid_rst_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        run_stream(0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
